// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
// A write request travels packed as {pc, data, addr}.
package rf_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int PC_W       = 32;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_FIFO = 2'd2
    } grant_e;

    function automatic int req_bus_w(input int data_w, input int addr_w);
        return PC_W + data_w + addr_w;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO for MDU results: same-cycle push+pop, no bypass.
// Pointers wrap naturally because DEPTH is a power of two.
module rf_wb_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (cnt_r == CNT_W'(DEPTH));
    assign empty     = (cnt_r == {CNT_W{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign cnt       = cnt_r;

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single RF write port between the WB stage and queued MDU results:
// WB has priority, but a waiting MDU result is forced after STARVE_MAX WB wins.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_valid,
    input  logic                          wb_we,
    input  logic [ADDR_W-1:0]             wb_addr,
    input  logic [DATA_W-1:0]             wb_data,
    input  logic [PC_W-1:0]               wb_pc,
    output logic                          wb_ready,
    input  logic                          mdu_valid,
    input  logic [ADDR_W-1:0]             mdu_addr,
    input  logic [DATA_W-1:0]             mdu_data,
    input  logic [PC_W-1:0]               mdu_pc,
    output logic                          mdu_ready,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic [PC_W-1:0]               debug_wb_pc,
    output logic [3:0]                    debug_wb_rf_wen,
    output logic [ADDR_W-1:0]             debug_wb_rf_wnum,
    output logic [DATA_W-1:0]             debug_wb_rf_wdata
);

    localparam int REQ_W = req_bus_w(DATA_W, ADDR_W);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    logic             wb_req_s;
    logic             fifo_req_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             mdu_push_s;
    logic             fifo_pop_s;
    grant_e           grant_s;
    logic [SC_W-1:0]  starve_cnt_r;
    logic [REQ_W-1:0] wb_bus_s;
    logic [REQ_W-1:0] mdu_bus_s;
    logic [REQ_W-1:0] fifo_bus_s;
    logic [REQ_W-1:0] sel_bus_s;

    assign wb_bus_s   = {wb_pc, wb_data, wb_addr};
    assign mdu_bus_s  = {mdu_pc, mdu_data, mdu_addr};
    assign wb_req_s   = wb_valid & wb_we;
    assign fifo_req_s = ~fifo_empty_s;

    // A full FIFO refuses the MDU even when it pops this cycle.
    assign mdu_ready  = ~reset & ~fifo_full_s;
    assign mdu_push_s = mdu_valid & mdu_ready;
    assign fifo_pop_s = (grant_s == GRANT_FIFO);
    assign wb_ready   = reset | ~wb_req_s | (grant_s == GRANT_WB);

    rf_wb_fifo #(
        .W     (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (mdu_push_s),
        .wdata (mdu_bus_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_bus_s),
        .cnt   (fifo_cnt),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Fixed priority to WB, overridden once the FIFO has waited STARVE_MAX wins.
    always_comb begin
        grant_s = GRANT_NONE;
        if (reset) begin
            grant_s = GRANT_NONE;
        end else if (fifo_req_s && (starve_cnt_r == STARVE_LIM)) begin
            grant_s = GRANT_FIFO;
        end else if (wb_req_s) begin
            grant_s = GRANT_WB;
        end else if (fifo_req_s) begin
            grant_s = GRANT_FIFO;
        end else begin
            grant_s = GRANT_NONE;
        end
    end

    // Counts WB wins taken while an MDU result was waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (grant_s == GRANT_FIFO) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if ((grant_s == GRANT_WB) && fifo_req_s && (starve_cnt_r != STARVE_LIM)) begin
            starve_cnt_r <= starve_cnt_r + SC_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Route the granted request onto the write port; zero when idle.
    always_comb begin
        sel_bus_s = {REQ_W{1'b0}};
        case (grant_s)
            GRANT_WB:   sel_bus_s = wb_bus_s;
            GRANT_FIFO: sel_bus_s = fifo_bus_s;
            default:    sel_bus_s = {REQ_W{1'b0}};
        endcase
    end

    assign rf_waddr    = sel_bus_s[ADDR_W-1:0];
    assign rf_wdata    = sel_bus_s[ADDR_W +: DATA_W];
    assign debug_wb_pc = sel_bus_s[ADDR_W + DATA_W +: PC_W];
    // r0 writes are consumed but never reach the register file.
    assign rf_we       = (grant_s != GRANT_NONE) && (rf_waddr != {ADDR_W{1'b0}});

    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: each step queues the write it expects;
// a negedge monitor pops and compares every RF write the DUT issues.
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int FD = 2;
    localparam int SM = 3;

    logic          clk;
    logic          reset;
    logic          wb_valid;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [31:0]   wb_pc;
    logic          wb_ready;
    logic          mdu_valid;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic [31:0]   mdu_pc;
    logic          mdu_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [$clog2(FD):0] fifo_cnt;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_wen;
    logic [AW-1:0] debug_wb_rf_wnum;
    logic [DW-1:0] debug_wb_rf_wdata;

    rf_wb_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (FD),
        .STARVE_MAX (SM)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_valid          (wb_valid),
        .wb_we             (wb_we),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .wb_pc             (wb_pc),
        .wb_ready          (wb_ready),
        .mdu_valid         (mdu_valid),
        .mdu_addr          (mdu_addr),
        .mdu_data          (mdu_data),
        .mdu_pc            (mdu_pc),
        .mdu_ready         (mdu_ready),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .fifo_cnt          (fifo_cnt),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, want);
        end
    endtask

    // One clock of stimulus: drive inputs, queue the expected write, check handshakes.
    task automatic step(input logic rst,
                        input logic wv, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [31:0] wp,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md, input logic [31:0] mp,
                        input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic [31:0] ep,
                        input logic ewbr, input logic emdr, input int ecnt);
        @(posedge clk);
        #1;
        cyc++;
        reset     = rst;
        wb_valid  = wv;
        wb_we     = we;
        wb_addr   = wa;
        wb_data   = wd;
        wb_pc     = wp;
        mdu_valid = mv;
        mdu_addr  = ma;
        mdu_data  = md;
        mdu_pc    = mp;
        if (ew) begin
            exp_q.push_back('{cyc, ea, ed, ep});
        end
        #3;
        chk("wb_ready", {31'd0, wb_ready}, {31'd0, ewbr});
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, emdr});
        chk("fifo_cnt", 32'(fifo_cnt), 32'(ecnt));
        chk("rf_we", {31'd0, rf_we}, {31'd0, ew});
        chk("debug_wen", {28'd0, debug_wb_rf_wen}, {28'd0, {4{ew}}});
    endtask

    // Monitor: every RF write must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_write cycle=%0d actual addr=%h data=%h required none", cyc, rf_waddr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("wr_addr", {27'd0, rf_waddr}, {27'd0, mon_e.addr});
                chk("wr_data", rf_wdata, mon_e.data);
                chk("wr_pc", debug_wb_pc, mon_e.pc);
                chk("dbg_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, mon_e.addr});
                chk("dbg_wdata", debug_wb_rf_wdata, mon_e.data);
            end
        end
    end

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; wb_pc = 32'd0;
        mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0; mdu_pc = 32'd0;

        // reset held with live requests: outputs gated
        step(1'b1, 1'b1,1'b1,5'd3,32'hAAAA,32'h10, 1'b1,5'd4,32'hBBBB,32'h20, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b0,0);
        step(1'b1, 1'b1,1'b1,5'd3,32'hAAAA,32'h10, 1'b1,5'd4,32'hBBBB,32'h20, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b0,0);
        // idle
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);
        // WB only
        step(1'b0, 1'b1,1'b1,5'd5,32'h1234,32'h100, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd5,32'h1234,32'h100, 1'b1,1'b1,0);
        // MDU only: push, write next cycle, then empty
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b1,5'd7,32'hDEAD,32'h200, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd7,32'hDEAD,32'h200, 1'b1,1'b1,1);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);

        // starvation: one queued entry, WB writing every cycle
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1,1'b1,5'd9,32'h900 + 32'(k),32'h400 + 32'(k), (k == 0),5'd8,32'h88,32'h300,
                 1'b1,5'd9,32'h900 + 32'(k),32'h400 + 32'(k), 1'b1,1'b1,(k == 0) ? 0 : 1);
        end
        step(1'b0, 1'b1,1'b1,5'd9,32'h904,32'h404, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd8,32'h88,32'h300, 1'b0,1'b1,1);
        step(1'b0, 1'b1,1'b1,5'd9,32'h904,32'h404, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd9,32'h904,32'h404, 1'b1,1'b1,0);

        // full FIFO with held MDU request
        step(1'b0, 1'b1,1'b1,5'd9,32'hA00,32'h500, 1'b1,5'd10,32'hA,32'h600, 1'b1,5'd9,32'hA00,32'h500, 1'b1,1'b1,0);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA01,32'h501, 1'b1,5'd11,32'hB,32'h601, 1'b1,5'd9,32'hA01,32'h501, 1'b1,1'b1,1);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA02,32'h502, 1'b1,5'd12,32'hC,32'h602, 1'b1,5'd9,32'hA02,32'h502, 1'b1,1'b0,2);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA03,32'h503, 1'b1,5'd12,32'hC,32'h602, 1'b1,5'd9,32'hA03,32'h503, 1'b1,1'b0,2);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA04,32'h504, 1'b1,5'd12,32'hC,32'h602, 1'b1,5'd10,32'hA,32'h600, 1'b0,1'b0,2);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA04,32'h504, 1'b1,5'd12,32'hC,32'h602, 1'b1,5'd9,32'hA04,32'h504, 1'b1,1'b1,1);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA05,32'h505, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd9,32'hA05,32'h505, 1'b1,1'b0,2);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA06,32'h506, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd9,32'hA06,32'h506, 1'b1,1'b0,2);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA07,32'h507, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd11,32'hB,32'h601, 1'b0,1'b0,2);
        step(1'b0, 1'b1,1'b1,5'd9,32'hA07,32'h507, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd9,32'hA07,32'h507, 1'b1,1'b1,1);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,5'd12,32'hC,32'h602, 1'b1,1'b1,1);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);

        // r0 writes from both sources are consumed silently; non-writing WB retires
        step(1'b0, 1'b1,1'b1,5'd0,32'h55,32'h700, 1'b1,5'd0,32'h66,32'h701, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,1);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);
        step(1'b0, 1'b1,1'b0,5'd6,32'h77,32'h702, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);

        // fill the FIFO, then reset discards both entries
        step(1'b0, 1'b1,1'b1,5'd14,32'hE00,32'h800, 1'b1,5'd13,32'hD,32'h801, 1'b1,5'd14,32'hE00,32'h800, 1'b1,1'b1,0);
        step(1'b0, 1'b1,1'b1,5'd14,32'hE01,32'h801, 1'b1,5'd15,32'hE,32'h802, 1'b1,5'd14,32'hE01,32'h801, 1'b1,1'b1,1);
        step(1'b1, 1'b1,1'b1,5'd14,32'hE02,32'h802, 1'b1,5'd16,32'hF,32'h803, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b0,2);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);
        step(1'b0, 1'b0,1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,32'd0, 1'b1,1'b1,0);

        @(posedge clk);
        #1;
        nchk++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL pending_writes actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Owns the single register-file write port and shares it between two requesters: the in-order pipeline writeback (WB stage) and the multi-cycle multiply/divide unit (MDU).
- MDU results are queued in a small FIFO.
- Each cycle, a fixed-priority-with-anti-starvation scheme grants at most one write.
- The granted write drives the RF write port, the ID forwarding bus and the debug trace interface.
- Sits between the WB stage / MDU and the register file in ID.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
FIFO_DEPTH, 2, MDU result queue entries (power of two, >=2)
STARVE_MAX, 3, consecutive WB wins allowed while FIFO is non-empty before the FIFO is forced

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
wb_valid  in  1  WB stage holds a valid instruction
wb_we  in  1  that instruction writes the RF
wb_addr  in  ADDR_W  destination register
wb_data  in  DATA_W  write data
wb_pc  in  32  instruction PC
wb_ready  out  1  WB instruction retires this cycle (feeds WB_ready_go)
mdu_valid  in  1  MDU result available
mdu_addr  in  ADDR_W  MDU destination register
mdu_data  in  DATA_W  MDU result
mdu_pc  in  32  PC of the MDU instruction
mdu_ready  out  1  FIFO accepts the MDU result this cycle
rf_we  out  1  RF write enable
rf_waddr  out  ADDR_W  RF write address
rf_wdata  out  DATA_W  RF write data
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupied entries (for ID scoreboard/stall)
debug_wb_pc  out  32  PC of the granted write
debug_wb_rf_wen  out  4  {4{rf_we}}
debug_wb_rf_wnum  out  ADDR_W  rf_waddr
debug_wb_rf_wdata  out  DATA_W  rf_wdata

Behaviour:
- Requests:
  - wb_req = wb_valid & wb_we.
  - fifo_req = FIFO non-empty.
- Push: mdu_push = mdu_valid & mdu_ready.
  - mdu_ready = (fifo_cnt < FIFO_DEPTH); full-with-pop does not accept.
  - Pushed entry is visible as a request the next cycle. There is no bypass, so MDU-to-RF latency is at least 1 cycle.
- Grant, combinational, decided from the current state:
  - fifo_req & (starve_cnt == STARVE_MAX): grant FIFO.
  - else wb_req: grant WB.
  - else fifo_req: grant FIFO.
  - else: no grant.
- wb_ready = ~wb_req | grant_wb.
  - A WB instruction with wb_we=0 always retires.
  - A writing WB instruction stalls only in a cycle where the FIFO is forced.
- starve_cnt, registered:
  - Cleared on reset or on FIFO grant.
  - Incremented (saturating at STARVE_MAX) when WB is granted while fifo_req=1.
  - Otherwise holds.
- FIFO pop occurs when the FIFO is granted. Push and pop may occur in the same cycle; fifo_cnt is then unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH.
- Write port outputs:
  - rf_waddr, rf_wdata and debug_wb_pc come from the granted source; they are 0 when there is no grant.
  - rf_we = grant & (rf_waddr != 0). A write to r0 is consumed (retires or pops) but not written.
- WAW ordering between WB and MDU to the same register is not resolved here. The ID scoreboard must block issue of a younger writer while an MDU write to that register is pending. The arbiter never reorders FIFO entries.
- Reset, including mid-operation:
  - FIFO emptied; pointers, fifo_cnt and starve_cnt = 0.
  - Queued results are discarded; the pipeline flushes concurrently.
  - While reset=1, rf_we=0, wb_ready=1, mdu_ready=0, and all debug outputs are 0.

Decomposition:
- Shared header macros: DATA_W/ADDR_W defaults and the bus width for a packed write request {pc, data, addr}, reused by WB and MDU bus packing.
- One natural sub-module: rf_wb_fifo, a parameterised synchronous FIFO with push/pop/cnt/full/empty, same-cycle push+pop and no bypass.
- Grant logic and starve_cnt stay in the top module.

Test Plan:
- Reset, then idle with wb_valid=0 and mdu_valid=0: rf_we=0, wb_ready=1, mdu_ready=1, fifo_cnt=0.
- WB only: wb_valid=1, wb_we=1, wb_addr=5, wb_data=0x1234: same cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_ready=1, debug_wb_rf_wen=4'hF.
- MDU only: push addr=7, data=0xDEAD at cycle t: fifo_cnt=1 at t+1, rf_we=1 with waddr=7 at t+1, fifo_cnt=0 at t+2.
- Starvation: FIFO holds 1 entry while WB writes every cycle: WB is granted 3 consecutive cycles, the 4th cycle grants the FIFO with wb_ready=0, WB is granted the next cycle, and starve_cnt=0 after the FIFO grant.
- Full: 2 pushes while WB writes continuously: mdu_ready=0 at fifo_cnt=2. A mdu_valid held high is accepted the cycle after the forced pop. No entry is lost or duplicated (scoreboard compares against the expected queue).
- r0 write: wb_addr=0 with wb_we=1: wb_ready=1, rf_we=0. An MDU entry with addr 0 pops with rf_we=0.
- Reset mid-operation: assert reset with fifo_cnt=2: next cycle fifo_cnt=0, and no rf_we for the discarded entries after reset deasserts.
